axis_pkt_gen: RTL
=================

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter SPT_VALUE, default 8'h00: constant placed on TUSER[23:16].
REQ-002 SHALL have port ACLK, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port ARESET, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port START, input, 1: one-cycle request to send one packet.
REQ-005 SHALL have port LEN_BYTES, input, 16: packet length in bytes, sampled with START.
REQ-006 SHALL have port DPT, input, 8: destination port, sampled with START.
REQ-007 SHALL have port SEED, input, 32: first data word / LFSR seed, sampled with START.
REQ-008 SHALL have port BUSY, output, 1: high while a packet is in progress.
REQ-009 SHALL have port DONE, output, 1: one-cycle pulse on packet completion.
REQ-010 SHALL have port PKT_COUNT, output, 32: count of completed packets.
REQ-011 SHALL have M_AXIS_DAT_TDATA (output, 32), TVALID (output, 1), TSTRB (output, 4), TUSER (output, 128), TLAST (output, 1) and TREADY (input, 1): AXI4-Stream master feeding the OPED S_AXIS slave.

Function
REQ-012 SHALL implement states IDLE and SEND: IDLE->SEND on START with LEN_BYTES>0; SEND->IDLE on the handshake of the TLAST beat.
REQ-013 SHALL assert TVALID on the cycle after START is accepted (1-cycle latency) and hold it through SEND.
REQ-014 SHALL ignore START while BUSY; LEN_BYTES/DPT/SEED changes during SEND SHALL have no effect.
REQ-015 START with LEN_BYTES=0 in IDLE SHALL send no beats, stay in IDLE, pulse DONE next cycle and leave PKT_COUNT unchanged.
REQ-016 SHALL send ceil(LEN_BYTES/4) beats; a beat completes only when TVALID and TREADY are both high.
REQ-017 SHALL hold TDATA, TSTRB, TUSER and TLAST stable while TVALID is high and TREADY is low.
REQ-018 SHALL drive TSTRB=4'hF on non-last beats; on the last beat 4'h1/4'h3/4'h7/4'hF for LEN_BYTES mod 4 = 1/2/3/0.
REQ-019 SHALL assert TLAST only on the final beat.
REQ-020 SHALL drive TUSER[15:0]=latched length, TUSER[23:16]=SPT_VALUE, TUSER[31:24]=latched DPT and TUSER[127:32]=0, constant for the whole packet.
REQ-021 SHALL drive TDATA on beat k (0-based) as the latched SEED+k (mod 2^32) when REQ-031 is not in effect.
REQ-022 BUSY SHALL be high from the cycle after START acceptance until the cycle after the last handshake.
REQ-023 DONE SHALL pulse exactly one cycle, on the cycle after the last handshake.
REQ-024 PKT_COUNT SHALL increment on that same cycle and wrap from 32'hFFFFFFFF to 0.
REQ-025 A START that arrives in the DONE cycle (state IDLE) SHALL be accepted, giving back-to-back packets with one idle cycle between them.
REQ-026 A 1-beat packet (LEN_BYTES 1..4) SHALL assert TLAST on its only beat.

Reset
REQ-027 While ARESET is high, TVALID, TLAST, BUSY and DONE SHALL be 0, TDATA/TSTRB/TUSER SHALL be 0, PKT_COUNT SHALL be 0, and the state SHALL be IDLE.
REQ-028 ARESET asserted mid-packet SHALL drop TVALID on the next edge and abandon the packet without a DONE pulse or count update.
REQ-029 START coincident with ARESET SHALL be ignored.

Configuration
REQ-030 Macro AXIS_PKT_GEN_LFSR_EN SHALL select the data pattern.
REQ-031 With AXIS_PKT_GEN_LFSR_EN defined:
- TDATA beat 0 SHALL equal SEED, or 32'h1 if SEED=0.
- Each later beat SHALL be the 32-bit Galois LFSR (x^32+x^22+x^2+x+1) advanced once per handshake.
REQ-032 Without AXIS_PKT_GEN_LFSR_EN, the incrementing pattern of REQ-021 SHALL apply and no LFSR logic SHALL be present.

Verification
REQ-033 LEN_BYTES=16, SEED=32'h100, DPT=8'h05, TREADY=1:
- 4 beats 0x100..0x103, TSTRB=F on all beats, TLAST on beat 3.
- TUSER[31:0]=32'h0500_0010.
- DONE pulse, PKT_COUNT=1.
REQ-034 LEN_BYTES=7, TREADY toggled 1,0,0,1: 2 beats, data held stable during stalls, last TSTRB=4'h7.
REQ-035 LEN_BYTES=0 -> no TVALID, DONE one cycle later, PKT_COUNT unchanged; START during BUSY -> ignored.
REQ-036 ARESET on beat 2 of an 8-beat packet -> TVALID=0 next cycle, no DONE, PKT_COUNT=0; a new START then sends a full packet.
REQ-037 Checks for PKT_COUNT and the LFSR pattern:
- Back-to-back START in each DONE cycle, 3 packets -> PKT_COUNT=3.
- With AXIS_PKT_GEN_LFSR_EN and SEED=0 -> beat 0 = 32'h1, beat 1 = next LFSR value.

Source files
------------

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream data channel between the packet generator (master) and the OPED slave.
interface axis_pkt_gen_if;
    logic [31:0]  TDATA;
    logic         TVALID;
    logic [3:0]   TSTRB;
    logic [127:0] TUSER;
    logic         TLAST;
    logic         TREADY;

    modport master (output TDATA, TVALID, TSTRB, TUSER, TLAST, input TREADY);
    modport slave  (input TDATA, TVALID, TSTRB, TUSER, TLAST, output TREADY);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: one packet of ceil(LEN_BYTES/4) beats per START.
// Define AXIS_PKT_GEN_LFSR_EN for a Galois LFSR data pattern instead of SEED+k.
//
// state | meaning
// IDLE  | waiting for START; zero-length START only pulses DONE
// SEND  | TVALID high, beats advance on each TVALID&TREADY handshake
module axis_pkt_gen #(
    parameter logic [7:0] SPT_VALUE = 8'h00
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                START,
    input  logic [15:0]         LEN_BYTES,
    input  logic [7:0]          DPT,
    input  logic [31:0]         SEED,
    output logic                BUSY,
    output logic                DONE,
    output logic [31:0]         PKT_COUNT,
    axis_pkt_gen_if.master      M_AXIS_DAT
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  dpt_q, dpt_d;
    logic [31:0] data_q, data_d;
    logic [14:0] beats_q, beats_d;
    logic        done_q, done_d;
    logic [31:0] count_q, count_d;

    logic [16:0] len_plus3;
    logic [14:0] beats_init;
    logic [31:0] data_init;
    logic [31:0] data_next;
    logic        last_beat;
    logic [3:0]  strb_last;

    assign len_plus3  = {1'b0, LEN_BYTES} + 17'd3;
    assign beats_init = len_plus3[16:2];

`ifdef AXIS_PKT_GEN_LFSR_EN
    // Zero would lock the LFSR, so it is replaced by 1.
    assign data_init = (SEED == 32'h0) ? 32'h1 : SEED;
    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    assign data_next = {1'b0, data_q[31:1]} ^ (data_q[0] ? 32'h8020_0003 : 32'h0);
`else
    assign data_init = SEED;
    assign data_next = data_q + 32'd1;
`endif

    assign last_beat = (state_q == SEND) && (beats_q == 15'd1);

    always_comb begin
        case (len_q[1:0])
            2'd1:    strb_last = 4'h1;
            2'd2:    strb_last = 4'h3;
            2'd3:    strb_last = 4'h7;
            default: strb_last = 4'hF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        dpt_d   = dpt_q;
        data_d  = data_q;
        beats_d = beats_q;
        done_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (LEN_BYTES != 16'd0) begin
                        state_d = SEND;
                        len_d   = LEN_BYTES;
                        dpt_d   = DPT;
                        data_d  = data_init;
                        beats_d = beats_init;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (M_AXIS_DAT.TREADY) begin
                    if (beats_q == 15'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        count_d = count_q + 32'd1;
                    end else begin
                        beats_d = beats_q - 15'd1;
                        data_d  = data_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            len_q   <= 16'h0;
            dpt_q   <= 8'h0;
            data_q  <= 32'h0;
            beats_q <= 15'h0;
            done_q  <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dpt_q   <= dpt_d;
            data_q  <= data_d;
            beats_q <= beats_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign BUSY      = (state_q == SEND);
    assign DONE      = done_q;
    assign PKT_COUNT = count_q;

    assign M_AXIS_DAT.TVALID = (state_q == SEND);
    assign M_AXIS_DAT.TLAST  = last_beat;
    assign M_AXIS_DAT.TDATA  = data_q;
    assign M_AXIS_DAT.TSTRB  = (state_q != SEND) ? 4'h0 : (last_beat ? strb_last : 4'hF);
    assign M_AXIS_DAT.TUSER  = {96'h0, dpt_q, SPT_VALUE, len_q};

endmodule
